aes_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_round.sv | 52 +++++
 rtl/aes_cipher_iter.sv | 112 +++++++++++
 tb/tb_aes_cipher_iter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the iterative cipher and round logic.
//   - aes_state_t : cipher FSM states
//   - sbox()      : FIPS-197 forward S-box
//   - xtime()     : multiply by x in GF(2^8)
//   - gf_mul()    : general GF(2^8) multiply
//   - nr_of()     : rounds for a given key length in words
//   - rk_msb()    : MSB position of round key r in the packed schedule
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } aes_state_t;

  localparam logic [0:255][7:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  // Round key 0 occupies the MSBs of the schedule.
  function automatic int unsigned rk_msb(input int unsigned nr, input int unsigned r);
    return 128 * (nr + 1) - 1 - 128 * r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round.
//   state     - current 128-bit state, FIPS byte 0 in [127:120], column-major
//   rk        - round key to add
//   final_rnd - 1 skips MixColumns (last round)
//   next      - resulting state
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] next
);

  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mx [16];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) w_sb[i] = sbox(state[127-8*i -: 8]);
  end

  // Byte index is row + 4*column; row r rotates left by r columns.
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = w_sr[4*c];
      a1 = w_sr[4*c + 1];
      a2 = w_sr[4*c + 2];
      a3 = w_sr[4*c + 3];
      w_mx[4*c]     = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
      w_mx[4*c + 1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
      w_mx[4*c + 2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
      w_mx[4*c + 3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      next[127-8*i -: 8] = (final_rnd ? w_sr[i] : w_mx[i]) ^ rk[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128/192/256 encryption, one round per clock.
//   clk, reset - clock and synchronous active-high reset
//   start      - encrypt in_block (taken only while ready)
//   ready      - idle, start accepted
//   in_block   - plaintext, FIPS byte 0 in [127:120]
//   w          - expanded key schedule, round key 0 in the MSBs; hold stable
//                from the accepting edge through the done cycle
//   out_block  - ciphertext, held until the next done
//   done       - one-cycle completion pulse
//   busy       - rounds in progress
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = nr_of(NK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [127:0]           in_block,
  input  logic [128*(NR+1)-1:0]  w,
  output logic [127:0]           out_block,
  output logic                   done,
  output logic                   busy
);

  localparam int RW = $clog2(NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $fatal(1, "aes_cipher_iter: NK must be 4, 6 or 8");
  end

  aes_state_t     r_state;
  logic [RW-1:0]  r_rnd;
  logic [127:0]   r_st;
  logic [127:0]   r_out;
  logic           r_ready;
  logic           r_done;
  logic           r_busy;

  logic [127:0]   w_rks [NR+1];
  logic [127:0]   w_next;
  logic           w_final;

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign w_rks[g] = w[rk_msb(NR, g) -: 128];
  end

  assign w_final = (r_rnd == RW'(NR));

  aes_round u_round (
    .state     (r_st),
    .rk        (w_rks[r_rnd]),
    .final_rnd (w_final),
    .next      (w_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rnd   <= '0;
      r_st    <= '0;
      r_out   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_st    <= in_block ^ w_rks[0];
            r_rnd   <= RW'(1);
            r_state <= ST_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_st <= w_next;
          if (w_final) begin
            // Output captured alongside the last state update so done and
            // out_block appear together.
            r_out   <= w_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_rnd   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_rnd <= r_rnd + 1'b1;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign busy      = r_busy;
  assign out_block = r_out;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 Appendix C vectors for all
// three key lengths, start-ignore, mid-run reset and back-to-back blocks.
module tb_aes_cipher_iter;
  import aes_pkg::*;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start4, ready4, done4, busy4;
  logic [127:0]  in4, out4;
  logic [1407:0] w4;
  logic          start6, ready6, done6, busy6;
  logic [127:0]  in6, out6;
  logic [1663:0] w6;
  logic          start8, ready8, done8, busy8;
  logic [127:0]  in8, out8;
  logic [1919:0] w8;

  int n_pass  = 0;
  int n_total = 0;

  aes_cipher_iter #(.NK(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .ready(ready4), .in_block(in4),
    .w(w4), .out_block(out4), .done(done4), .busy(busy4));
  aes_cipher_iter #(.NK(6)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6), .ready(ready6), .in_block(in6),
    .w(w6), .out_block(out6), .done(done6), .busy(busy6));
  aes_cipher_iter #(.NK(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .ready(ready8), .in_block(in8),
    .w(w8), .out_block(out8), .done(done8), .busy(busy8));

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // Key bytes 00,01,02,...; result has word 0 in the MSBs, zero-padded below.
  function automatic logic [1919:0] expand_key(input int unsigned nk);
    logic [31:0]   wk [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] v;
    int unsigned   nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    v  = '0;
    for (int unsigned i = 0; i < 60; i++) begin
      wk[i] = '0;
      if (i < nk) begin
        wk[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
      end else if (i < nw) begin
        t = wk[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        wk[i] = wk[i-nk] ^ t;
      end
      v = {v[1887:0], wk[i]};
    end
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ready4 !== 1'b1) $display("FAIL reset_ready4: got %b want 1", ready4); else n_pass++;
    n_total++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b want 0", busy4); else n_pass++;
    n_total++; if (done4 !== 1'b0) $display("FAIL reset_done4: got %b want 0", done4); else n_pass++;
    n_total++; if (out4 !== 128'h0) $display("FAIL reset_out4: got %h want 0", out4); else n_pass++;
    n_total++; if (ready6 !== 1'b1 || ready8 !== 1'b1)
      $display("FAIL reset_ready68: got %b%b want 11", ready6, ready8); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_nk4();
    int unsigned lat, nbusy;
    bit          both;
    lat = 0; nbusy = 0; both = 0;
    @(posedge clk); #1;
    in4 = PT; start4 = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start4 = 1'b0;
        in4 = {$urandom, $urandom, $urandom, $urandom};
      end
      if (busy4) nbusy++;
      if (ready4 && done4) both = 1;
    end while (!done4 && lat < 40);
    n_total++; if (lat != 11) $display("FAIL nk4_latency: got %0d want 11", lat); else n_pass++;
    n_total++; if (out4 !== CT4) $display("FAIL nk4_cipher: got %h want %h", out4, CT4); else n_pass++;
    n_total++; if (nbusy != 10) $display("FAIL nk4_busy_cycles: got %0d want 10", nbusy); else n_pass++;
    n_total++; if (both) $display("FAIL nk4_ready_done_overlap: got 1 want 0"); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done4 !== 1'b0) $display("FAIL nk4_done_pulse: got %b want 0", done4); else n_pass++;
    n_total++; if (ready4 !== 1'b1) $display("FAIL nk4_ready_after: got %b want 1", ready4); else n_pass++;
    n_total++; if (out4 !== CT4) $display("FAIL nk4_out_hold: got %h want %h", out4, CT4); else n_pass++;
  endtask

  task automatic test_nk6();
    int unsigned lat;
    lat = 0;
    @(posedge clk); #1;
    in6 = PT; start6 = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin start6 = 1'b0; in6 = '0; end
    end while (!done6 && lat < 40);
    n_total++; if (lat != 13) $display("FAIL nk6_latency: got %0d want 13", lat); else n_pass++;
    n_total++; if (out6 !== CT6) $display("FAIL nk6_cipher: got %h want %h", out6, CT6); else n_pass++;
  endtask

  task automatic test_nk8();
    int unsigned lat;
    lat = 0;
    @(posedge clk); #1;
    in8 = PT; start8 = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin start8 = 1'b0; in8 = '1; end
    end while (!done8 && lat < 40);
    n_total++; if (lat != 15) $display("FAIL nk8_latency: got %0d want 15", lat); else n_pass++;
    n_total++; if (out8 !== CT8) $display("FAIL nk8_cipher: got %h want %h", out8, CT8); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int unsigned  ndone, nready;
    logic [127:0] got;
    ndone = 0; nready = 0; got = '0;
    @(posedge clk); #1;
    in4 = PT; start4 = 1'b1;
    for (int unsigned lat = 1; lat <= 20; lat++) begin
      @(posedge clk); #1;
      in4 = {$urandom, $urandom, $urandom, $urandom};
      if (ready4 && lat <= 11) nready++;
      if (done4) begin
        ndone++;
        if (ndone == 1) got = out4;
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    n_total++; if (got !== CT4) $display("FAIL ignore_cipher: got %h want %h", got, CT4); else n_pass++;
    n_total++; if (nready != 0) $display("FAIL ignore_ready_in_run: got %0d want 0", nready); else n_pass++;
    n_total++; if (ndone != 1) $display("FAIL ignore_done_count: got %0d want 1", ndone); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int unsigned ndone, lat;
    ndone = 0; lat = 0;
    @(posedge clk); #1;
    in4 = PT; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    // Four more rounds leaves the round counter at 5.
    repeat (4) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++; if (ready4 !== 1'b1) $display("FAIL midreset_ready: got %b want 1", ready4); else n_pass++;
    n_total++; if (busy4 !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy4); else n_pass++;
    n_total++; if (out4 !== 128'h0) $display("FAIL midreset_out: got %h want 0", out4); else n_pass++;
    repeat (15) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    n_total++; if (ndone != 0) $display("FAIL midreset_no_done: got %0d want 0", ndone); else n_pass++;
    in4 = PT; start4 = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start4 = 1'b0;
    end while (!done4 && lat < 40);
    n_total++; if (lat != 11) $display("FAIL midreset_restart_latency: got %0d want 11", lat); else n_pass++;
    n_total++; if (out4 !== CT4) $display("FAIL midreset_restart_cipher: got %h want %h", out4, CT4); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned  cyc, d1, d2;
    logic         rdy, bsy;
    logic [127:0] ct1, ct2;
    cyc = 0; d1 = 0; d2 = 0; rdy = 1'b0; bsy = 1'b0; ct1 = '0; ct2 = '0;
    @(posedge clk); #1;
    in4 = PT; start4 = 1'b1;
    while (cyc < 40 && d2 == 0) begin
      @(posedge clk); #1;
      cyc++;
      if (d1 != 0 && cyc == d1 + 1) rdy = ready4;
      if (d1 != 0 && cyc == d1 + 2) bsy = busy4;
      if (done4) begin
        if (d1 == 0) begin
          d1 = cyc; ct1 = out4; in4 = PT;
        end else begin
          d2 = cyc; ct2 = out4; start4 = 1'b0;
        end
      end else if (!(d1 != 0 && cyc == d1 + 1)) begin
        in4 = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    start4 = 1'b0;
    n_total++; if (d1 != 11) $display("FAIL b2b_first_done: got %0d want 11", d1); else n_pass++;
    n_total++; if (d2 - d1 != 12) $display("FAIL b2b_done_spacing: got %0d want 12", d2 - d1); else n_pass++;
    n_total++; if (rdy !== 1'b1) $display("FAIL b2b_ready_after_done: got %b want 1", rdy); else n_pass++;
    n_total++; if (bsy !== 1'b1) $display("FAIL b2b_second_accepted: got %b want 1", bsy); else n_pass++;
    n_total++; if (ct1 !== CT4) $display("FAIL b2b_cipher1: got %h want %h", ct1, CT4); else n_pass++;
    n_total++; if (ct2 !== CT4) $display("FAIL b2b_cipher2: got %h want %h", ct2, CT4); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1919:0] full;
    reset  = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    in4 = '0; in6 = '0; in8 = '0;
    full = expand_key(4); w4 = full[1919 -: 1408];
    full = expand_key(6); w6 = full[1919 -: 1664];
    full = expand_key(8); w8 = full[1919 -: 1920];
    test_reset();
    test_nk4();
    test_nk6();
    test_nk8();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
